mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of all address buses.
REQ-002 Parameter: DATA_W, default 32, width of all data buses.
REQ-003 Parameter: CNT_W, default 16, width of the grant counters.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: if_req  input  1  instruction-fetch read request.
REQ-007 Port: if_addr  input  ADDR_W  fetch address.
REQ-008 Port: if_gnt  output  1  fetch request accepted this cycle.
REQ-009 Port: if_rvalid  output  1  fetch read data valid.
REQ-010 Port: if_rdata  output  DATA_W  fetch read data.
REQ-011 Port: ls_req  input  1  load/store request.
REQ-012 Port: ls_we  input  1  1 = store, 0 = load.
REQ-013 Port: ls_addr  input  ADDR_W  load/store address.
REQ-014 Port: ls_wdata  input  DATA_W  store data.
REQ-015 Port: ls_gnt  output  1  load/store request accepted this cycle.
REQ-016 Port: ls_rvalid  output  1  load data valid.
REQ-017 Port: ls_rdata  output  DATA_W  load data.
REQ-018 Port: mem_en  output  1  memory access strobe.
REQ-019 Port: mem_we  output  1  memory write enable.
REQ-020 Port: mem_addr  output  ADDR_W  memory address.
REQ-021 Port: mem_wdata  output  DATA_W  memory write data.
REQ-022 Port: mem_rdata  input  DATA_W  memory read data, valid one cycle after a read strobe.
REQ-023 Port: if_stall  output  1  fetch is pending but not granted; used to hold the PC.
REQ-024 Port: if_cnt  output  CNT_W  saturating count of fetch grants.
REQ-025 Port: ls_cnt  output  CNT_W  saturating count of load/store grants.

Function
REQ-026 Handshake: a transfer occurs in a cycle where req and gnt are both 1; gnt is combinational from req, rst and internal state; requesters hold req/addr/wdata until gnt.
REQ-027 At most one of if_gnt/ls_gnt SHALL be 1 in any cycle; gnt is never 1 without its req.
REQ-028 Single requester: granted in the same cycle, no bubble.
REQ-029 Both requesting: round-robin via 1-bit register last (0 = IF served last, 1 = LS served last); grant the port not served last.
REQ-030 last updates on every grant to the granted port; no grant leaves it unchanged.
REQ-031 mem_en = if_gnt | ls_gnt; mem_we = ls_gnt & ls_we; mem_addr/mem_wdata taken from the granted port; with no grant, mem_addr/mem_wdata = 0.
REQ-032 Read owner register: a granted read (fetch, or load) records its owner; next cycle that port's rvalid = 1 and its rdata = mem_rdata; stores produce no rvalid.
REQ-033 Reads are pipelined: back-to-back granted reads give rvalid on consecutive cycles, one read per cycle, latency exactly 1.
REQ-034 rdata of a port SHALL be 0 whenever its rvalid = 0.
REQ-035 if_stall = if_req & ~if_gnt.
REQ-036 if_cnt/ls_cnt increment by 1 on their port's grant and saturate at 2^CNT_W-1 (no wrap).

Reset
REQ-037 While rst = 1: if_gnt = ls_gnt = 0; mem_en = mem_we = 0; if_stall = if_req.
REQ-038 On a clock edge with rst = 1: last <= 1 (IF wins first contention), read owner cleared, if_cnt = ls_cnt = 0.
REQ-039 In the cycle after reset, if_rvalid = ls_rvalid = 0 and if_rdata = ls_rdata = 0, even if a read was granted in the cycle the reset edge occurred; that read is discarded.

Verification
REQ-040 Reset, then if_req=1 only, if_addr=0x10 -> if_gnt=1 same cycle, mem_en=1, mem_addr=0x10; next cycle if_rvalid=1, if_rdata=mem_rdata.
REQ-041 Both requesting continuously after reset -> grants alternate IF, LS, IF, LS; if_stall=1 on LS cycles; if_cnt=ls_cnt=2 after 4 cycles.
REQ-042 ls_req=1, ls_we=1, addr=0x20, wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF; no ls_rvalid next cycle.
REQ-043 Fetch then load on consecutive cycles -> if_rvalid in cycle 2, ls_rvalid in cycle 3, each with its own mem_rdata; the other port's rvalid=0.
REQ-044 rst asserted in the cycle after a granted read -> no rvalid and rdata=0; counters=0; next contention grants IF.
REQ-045 Force if_cnt to 0xFFFE, then 3 fetch grants -> if_cnt holds at 0xFFFF.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundles the fetch port, load/store port and memory port of the
//           two-to-one memory arbiter.
// Ports   : requester/memory side uses modport master, the arbiter uses slave.
//           Fetch:   if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//           LdSt:    ls_req, ls_we, ls_addr, ls_wdata -> ls_gnt, ls_rvalid, ls_rdata
//           Memory:  mem_en, mem_we, mem_addr, mem_wdata <- -> mem_rdata
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // load/store port
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  // shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus the memory: drive requests and read data, observe the rest.
  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-cycle memory port between instruction fetch and
//           load/store; round-robin on contention, same-cycle grant, 1-cycle
//           read latency routed back to the requesting port.
// Ports   : clk, rst (sync, active-high); bus (slave modport of
//           mem_port_arbiter_if); if_stall; if_cnt/ls_cnt saturating grant counts.
// Backpressure: a requester holds req/addr/wdata until it sees gnt.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus,
  output logic                 if_stall,
  output logic [CNT_W-1:0]     if_cnt,
  output logic [CNT_W-1:0]     ls_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // last_q: 0 = fetch was served most recently, 1 = load/store was.
  logic             last_q, last_d;
  // Read owner: which port receives mem_rdata in the following cycle.
  logic             rd_if_q, rd_if_d;
  logic             rd_ls_q, rd_ls_d;
  logic [CNT_W-1:0] if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0] ls_cnt_q, ls_cnt_d;

  logic             if_gnt_c;
  logic             ls_gnt_c;

  // ---------------------------------------------------------------------------
  // Grant: a lone requester wins immediately; on contention the port that was
  // not served last wins. Reset blocks every grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_gnt_c = 1'b0;
    ls_gnt_c = 1'b0;
    if (!rst) begin
      if (bus.if_req && bus.ls_req) begin
        if_gnt_c = last_q;
        ls_gnt_c = ~last_q;
      end else begin
        if_gnt_c = bus.if_req;
        ls_gnt_c = bus.ls_req;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d   = last_q;
    rd_if_d  = if_gnt_c;
    // stores return nothing, so only a load claims the read slot
    rd_ls_d  = ls_gnt_c & ~bus.ls_we;
    if_cnt_d = if_cnt_q;
    ls_cnt_d = ls_cnt_q;

    if (if_gnt_c) begin
      last_d = 1'b0;
    end else if (ls_gnt_c) begin
      last_d = 1'b1;
    end

    if (if_gnt_c && (if_cnt_q != CNT_MAX)) begin
      if_cnt_d = if_cnt_q + 1'b1;
    end
    if (ls_gnt_c && (ls_cnt_q != CNT_MAX)) begin
      ls_cnt_d = ls_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset leaves last = 1 so fetch wins the first contention,
  // and drops any read in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q   <= 1'b1;
      rd_if_q  <= 1'b0;
      rd_ls_q  <= 1'b0;
      if_cnt_q <= '0;
      ls_cnt_q <= '0;
    end else begin
      last_q   <= last_d;
      rd_if_q  <= rd_if_d;
      rd_ls_q  <= rd_ls_d;
      if_cnt_q <= if_cnt_d;
      ls_cnt_q <= ls_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.if_gnt    = if_gnt_c;
    bus.ls_gnt    = ls_gnt_c;
    bus.mem_en    = if_gnt_c | ls_gnt_c;
    bus.mem_we    = ls_gnt_c & bus.ls_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (if_gnt_c) begin
      bus.mem_addr  = bus.if_addr;
    end else if (ls_gnt_c) begin
      bus.mem_addr  = bus.ls_addr;
      bus.mem_wdata = bus.ls_wdata;
    end

    // A read whose data would land during reset is discarded; rdata is
    // forced to zero whenever its rvalid is low.
    bus.if_rvalid = rd_if_q & ~rst;
    bus.ls_rvalid = rd_ls_q & ~rst;
    bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
    bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;

    if_stall = bus.if_req & ~if_gnt_c;
    if_cnt   = if_cnt_q;
    ls_cnt   = ls_cnt_q;
  end

  // Only one requester may own the memory port in a cycle.
  a_onehot_gnt: assert property (@(posedge clk) !(if_gnt_c && ls_gnt_c));

endmodule
